coalescing_store_buffer: RTL and testbench

- Next-generation committed-store buffer between the memory stage and the data-cache write port.
- Parametrised in address width, data width and depth.
- Adds per-byte write enables, youngest-entry store coalescing, and newest-first per-byte load forwarding with partial-hit detection.
- Drains to memory through a valid/ready handshake.

---
 rtl/coalescing_store_buffer_if.sv | 42 ++++
 rtl/coalescing_store_buffer.sv | 142 ++++++++++++++
 tb/tb_coalescing_store_buffer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/coalescing_store_buffer_if.sv
// Store-buffer bus: enqueue, drain, forwarding and status signals.
// Master drives requests, slave (the buffer) returns ready, head entry and forwarding results.
interface coalescing_store_buffer_if #(
    parameter int ENTRY_COUNT = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CW    = $clog2(ENTRY_COUNT + 1);

    logic                  flush;
    logic                  enq_valid;
    logic [ADDR_WIDTH-1:0] enq_addr;
    logic [DATA_WIDTH-1:0] enq_data;
    logic [BYTES-1:0]      enq_be;
    logic                  enq_ready;
    logic                  mem_req_valid;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0] mem_req_data;
    logic [BYTES-1:0]      mem_req_be;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [BYTES-1:0]      load_be;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic                  fwd_hit;
    logic                  fwd_partial;
    logic [CW-1:0]         count_out;
    logic                  full;
    logic                  empty;

    modport master (
        output flush, enq_valid, enq_addr, enq_data, enq_be, mem_req_ready, load_addr, load_be,
        input  enq_ready, mem_req_valid, mem_req_addr, mem_req_data, mem_req_be,
               fwd_data, fwd_hit, fwd_partial, count_out, full, empty
    );

    modport slave (
        input  flush, enq_valid, enq_addr, enq_data, enq_be, mem_req_ready, load_addr, load_be,
        output enq_ready, mem_req_valid, mem_req_addr, mem_req_data, mem_req_be,
               fwd_data, fwd_hit, fwd_partial, count_out, full, empty
    );
endinterface

// File: rtl/coalescing_store_buffer.sv
// Committed-store FIFO with youngest-entry coalescing and newest-first per-byte load forwarding.
// Head visible on mem_req_* one cycle after enqueue; enq_ready drops when full unless the store merges.
module coalescing_store_buffer #(
    parameter int ENTRY_COUNT = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    coalescing_store_buffer_if.slave bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int PW    = $clog2(ENTRY_COUNT);
    localparam int CW    = $clog2(ENTRY_COUNT + 1);
    localparam int WAW   = ADDR_WIDTH - OFFS;

    logic            valid_q [ENTRY_COUNT];
    logic            valid_d [ENTRY_COUNT];
    logic [WAW-1:0]  waddr_q [ENTRY_COUNT];
    logic [WAW-1:0]  waddr_d [ENTRY_COUNT];
    logic [DATA_WIDTH-1:0] data_q [ENTRY_COUNT];
    logic [DATA_WIDTH-1:0] data_d [ENTRY_COUNT];
    logic [BYTES-1:0] be_q [ENTRY_COUNT];
    logic [BYTES-1:0] be_d [ENTRY_COUNT];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic [WAW-1:0]  enq_word;
    logic [WAW-1:0]  load_word;
    logic [PW-1:0]   young_idx;
    logic            coalesce;
    logic            is_full;
    logic            enq_fire;
    logic            enq_new;
    logic            drain_fire;
    logic [BYTES-1:0] covered;
    logic [PW-1:0]   scan_idx;
    logic            unused_low_bits;

    assign enq_word        = bus.enq_addr[ADDR_WIDTH-1:OFFS];
    assign load_word       = bus.load_addr[ADDR_WIDTH-1:OFFS];
    assign unused_low_bits = ^{bus.enq_addr[OFFS-1:0], bus.load_addr[OFFS-1:0]};
    assign young_idx       = tail_q - PW'(1);

    // The head is excluded from merging because count >= 2 keeps tail-1 away from it.
    assign coalesce   = (count_q >= CW'(2)) && valid_q[young_idx] && (waddr_q[young_idx] == enq_word);
    assign is_full    = (count_q == CW'(ENTRY_COUNT));
    assign bus.enq_ready = !bus.flush && (!is_full || coalesce);
    assign enq_fire   = bus.enq_valid && bus.enq_ready;
    assign enq_new    = enq_fire && !coalesce;
    assign drain_fire = bus.mem_req_valid && bus.mem_req_ready;

    assign bus.mem_req_valid = (count_q != '0);
    assign bus.mem_req_addr  = ADDR_WIDTH'(waddr_q[head_q]) << OFFS;
    assign bus.mem_req_data  = data_q[head_q];
    assign bus.mem_req_be    = be_q[head_q];
    assign bus.count_out     = count_q;
    assign bus.full          = is_full;
    assign bus.empty         = (count_q == '0);

    always_comb begin
        valid_d = valid_q;
        waddr_d = waddr_q;
        data_d  = data_q;
        be_d    = be_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            for (int i = 0; i < ENTRY_COUNT; i++) valid_d[i] = 1'b0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire) begin
                if (coalesce) begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (bus.enq_be[b]) data_d[young_idx][8*b +: 8] = bus.enq_data[8*b +: 8];
                    end
                    be_d[young_idx] = be_q[young_idx] | bus.enq_be;
                end else begin
                    valid_d[tail_q] = 1'b1;
                    waddr_d[tail_q] = enq_word;
                    data_d[tail_q]  = bus.enq_data;
                    be_d[tail_q]    = bus.enq_be;
                    tail_d          = tail_q + PW'(1);
                end
            end
            if (drain_fire) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + PW'(1);
            end
            count_d = count_q + CW'(enq_new) - CW'(drain_fire);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRY_COUNT; i++) begin
                valid_q[i] <= 1'b0;
                waddr_q[i] <= '0;
                data_q[i]  <= '0;
                be_q[i]    <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            waddr_q <= waddr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Walk oldest to youngest so a younger matching byte overwrites an older one.
    always_comb begin
        covered      = '0;
        bus.fwd_data = '0;
        scan_idx     = head_q;
        for (int i = 0; i < ENTRY_COUNT; i++) begin
            scan_idx = head_q + PW'(i);
            if (valid_q[scan_idx] && (waddr_q[scan_idx] == load_word)) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (be_q[scan_idx][b]) begin
                        covered[b]            = 1'b1;
                        bus.fwd_data[8*b +: 8] = data_q[scan_idx][8*b +: 8];
                    end
                end
            end
        end
    end

    assign bus.fwd_hit     = (bus.load_be != '0) && ((covered & bus.load_be) == bus.load_be);
    assign bus.fwd_partial = ((covered & bus.load_be) != '0) && !bus.fwd_hit;

endmodule

// File: tb/tb_coalescing_store_buffer.sv
// Directed and randomized bench for coalescing_store_buffer against a queue-based reference model.
module tb_coalescing_store_buffer;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BY = DW / 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    coalescing_store_buffer_if #(.ENTRY_COUNT(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    coalescing_store_buffer #(.ENTRY_COUNT(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BY-1:0] be;
    } ent_t;

    ent_t sb[$];

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return a & ~AW'(BY - 1);
    endfunction

    function automatic bit model_coalesce();
        return sb.size() >= 2 && sb[sb.size()-1].addr == align(bus.enq_addr);
    endfunction

    function automatic bit model_ready();
        return !bus.flush && (sb.size() < N || model_coalesce());
    endfunction

    task automatic check_outputs();
        logic [DW-1:0] fd;
        logic [BY-1:0] cov;
        bit hit;
        fd  = '0;
        cov = '0;
        for (int b = 0; b < BY; b++) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].addr == align(bus.load_addr) && sb[i].be[b]) begin
                    fd[8*b +: 8] = sb[i].data[8*b +: 8];
                    cov[b] = 1'b1;
                    break;
                end
            end
        end
        hit = (bus.load_be != 0) && ((cov & bus.load_be) == bus.load_be);
        check("count", bus.count_out, sb.size());
        check("full", bus.full, sb.size() == N);
        check("empty", bus.empty, sb.size() == 0);
        check("enq_ready", bus.enq_ready, model_ready());
        check("mem_req_valid", bus.mem_req_valid, sb.size() > 0);
        if (sb.size() > 0) begin
            check("mem_req_addr", bus.mem_req_addr, sb[0].addr);
            check("mem_req_data", bus.mem_req_data, sb[0].data);
            check("mem_req_be", bus.mem_req_be, sb[0].be);
        end
        check("fwd_data", bus.fwd_data, fd);
        check("fwd_hit", bus.fwd_hit, hit);
        check("fwd_partial", bus.fwd_partial, ((cov & bus.load_be) != 0) && !hit);
    endtask

    task automatic update_model();
        bit   rdy;
        bit   co;
        bit   drain;
        ent_t e;
        if (reset || bus.flush) begin
            sb.delete();
        end else begin
            rdy   = model_ready();
            co    = model_coalesce();
            drain = sb.size() > 0 && bus.mem_req_ready;
            if (bus.enq_valid && rdy) begin
                if (co) begin
                    e = sb[sb.size()-1];
                    for (int b = 0; b < BY; b++)
                        if (bus.enq_be[b]) e.data[8*b +: 8] = bus.enq_data[8*b +: 8];
                    e.be = e.be | bus.enq_be;
                    sb[sb.size()-1] = e;
                end else begin
                    e.addr = align(bus.enq_addr);
                    e.data = bus.enq_data;
                    e.be   = bus.enq_be;
                    sb.push_back(e);
                end
            end
            if (drain) void'(sb.pop_front());
        end
    endtask

    // One clock: outputs checked at the falling edge, model advanced on the rising edge.
    task automatic step();
        @(negedge clock);
        check_outputs();
        @(posedge clock);
        update_model();
        #1;
    endtask

    task automatic idle();
        bus.flush         = 1'b0;
        bus.enq_valid     = 1'b0;
        bus.enq_addr      = '0;
        bus.enq_data      = '0;
        bus.enq_be        = '0;
        bus.mem_req_ready = 1'b0;
        bus.load_addr     = '0;
        bus.load_be       = '0;
    endtask

    task automatic enq(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BY-1:0] be);
        bus.enq_valid = 1'b1;
        bus.enq_addr  = a;
        bus.enq_data  = d;
        bus.enq_be    = be;
        step();
        bus.enq_valid = 1'b0;
    endtask

    task automatic drain_all();
        bus.mem_req_ready = 1'b1;
        for (int i = 0; i < 2 * N && sb.size() > 0; i++) step();
        bus.mem_req_ready = 1'b0;
        check("drain_empty", bus.empty, 1);
    endtask

    task automatic set_load(input logic [AW-1:0] a, input logic [BY-1:0] be);
        bus.load_addr = a;
        bus.load_be   = be;
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        bus.load_be = 4'hF;
        repeat (2) @(posedge clock);
        #1;
        sb.delete();
        check("rst_enq_ready", bus.enq_ready, 1);
        check("rst_mem_valid", bus.mem_req_valid, 0);
        check("rst_hit", bus.fwd_hit, 0);
        check("rst_partial", bus.fwd_partial, 0);
        check("rst_fwd_data", bus.fwd_data, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_count", bus.count_out, 0);
        reset = 1'b0;

        enq(32'h100, 32'hAABBCCDD, 4'hF);
        check("t1_valid", bus.mem_req_valid, 1);
        check("t1_addr", bus.mem_req_addr, 32'h100);
        check("t1_be", bus.mem_req_be, 4'hF);
        check("t1_count", bus.count_out, 1);
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        check("t1_empty", bus.empty, 1);

        enq(32'h200, 32'h11, 4'h1);
        enq(32'h300, 32'hCAFEF00D, 4'hF);
        enq(32'h300, 32'h0000_2200, 4'h2);
        check("t2_count", bus.count_out, 2);
        set_load(32'h300, 4'hF);
        check("t2_fwd_data", bus.fwd_data, 32'hCAFE220D);
        check("t2_hit", bus.fwd_hit, 1);
        drain_all();

        enq(32'h40, 32'h11111111, 4'hF);
        enq(32'h80, 32'h12345678, 4'hF);
        enq(32'h40, 32'h000000FF, 4'h1);
        set_load(32'h40, 4'hF);
        check("t3_hit", bus.fwd_hit, 1);
        check("t3_fwd_data", bus.fwd_data, 32'h111111FF);
        set_load(32'h44, 4'h3);
        check("t3_miss_hit", bus.fwd_hit, 0);
        check("t3_miss_partial", bus.fwd_partial, 0);
        drain_all();

        enq(32'h50, 32'hDEADBEEF, 4'h3);
        set_load(32'h50, 4'hF);
        check("t4_partial", bus.fwd_partial, 1);
        check("t4_hit", bus.fwd_hit, 0);
        check("t4_fwd_data", bus.fwd_data, 32'h0000BEEF);
        drain_all();

        enq(32'h10, 32'hA0A0A0A0, 4'hF);
        enq(32'h20, 32'hB1B1B1B1, 4'hF);
        enq(32'h30, 32'hC2C2C2C2, 4'hF);
        enq(32'h40, 32'hD3D3D3D3, 4'hF);
        check("t5_full", bus.full, 1);
        bus.enq_addr = 32'h70;
        #1;
        check("t5_ready_new", bus.enq_ready, 0);
        bus.enq_addr = 32'h42;
        #1;
        check("t5_ready_young", bus.enq_ready, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_hold_addr", bus.mem_req_addr, 32'h10);
            check("t5_hold_data", bus.mem_req_data, 32'hA0A0A0A0);
        end
        bus.mem_req_ready = 1'b1;
        step();
        enq(32'h50, 32'hE4E4E4E4, 4'hF);
        bus.mem_req_ready = 1'b0;
        check("t5_count", bus.count_out, 3);
        check("t5_head", bus.mem_req_addr, 32'h30);
        drain_all();

        enq(32'h10, 32'h1, 4'hF);
        enq(32'h20, 32'h2, 4'hF);
        enq(32'h30, 32'h3, 4'hF);
        bus.flush = 1'b1;
        bus.mem_req_ready = 1'b1;
        bus.enq_valid = 1'b1;
        bus.enq_addr  = 32'h90;
        step();
        idle();
        check("t6_flush_count", bus.count_out, 0);
        check("t6_flush_valid", bus.mem_req_valid, 0);
        step();
        check("t6_flush_empty", bus.empty, 1);

        enq(32'h10, 32'h1, 4'hF);
        enq(32'h20, 32'h2, 4'hF);
        enq(32'h30, 32'h3, 4'hF);
        reset = 1'b1;
        bus.mem_req_ready = 1'b1;
        bus.enq_valid = 1'b1;
        bus.enq_addr  = 32'h90;
        step();
        reset = 1'b0;
        idle();
        check("t6_rst_count", bus.count_out, 0);
        check("t6_rst_valid", bus.mem_req_valid, 0);

        for (int i = 0; i < 3000; i++) begin
            reset             = ($urandom_range(0, 199) == 0);
            bus.flush         = ($urandom_range(0, 79) == 0);
            bus.enq_valid     = $urandom_range(0, 1);
            bus.enq_addr      = 32'h1000 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
            bus.enq_data      = $urandom;
            bus.enq_be        = 4'($urandom_range(0, 15));
            bus.mem_req_ready = ($urandom_range(0, 2) == 0);
            bus.load_addr     = 32'h1000 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
            bus.load_be       = 4'($urandom_range(0, 15));
            step();
        end
        reset = 1'b0;
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
